xor_burst_arbiter: RTL

Shares one N-bit XOR datapath between two requesters. Each requester streams a burst of words, and the block folds each burst into a single XOR checksum. A round-robin arbiter grants one burst at a time and gates word acceptance with valid/ready. The block returns the checksum together with the source identity in a one-cycle done pulse. It sits between the two producers and the team's combinational N-bit XOR cell, which it uses as its accumulate stage.

---
 rtl/xor_burst_arbiter_if.sv | 30 +++
 rtl/xor_burst_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/xor_burst_arbiter_if.sv
// Request/data/valid bundle from the two producers plus the grant, ready
// and checksum-result signals returned by xor_burst_arbiter.
interface xor_burst_arbiter_if #(
    parameter int NB_G  = 16,
    parameter int LEN_W = 4
);
    logic [1:0]       req_i;
    logic [LEN_W-1:0] len0_i;
    logic [LEN_W-1:0] len1_i;
    logic [NB_G-1:0]  data0_i;
    logic [NB_G-1:0]  data1_i;
    logic             valid0_i;
    logic             valid1_i;
    logic [1:0]       ready_o;
    logic [1:0]       gnt_o;
    logic             busy_o;
    logic             done_o;
    logic [NB_G-1:0]  sum_o;
    logic             src_o;

    modport master (
        output req_i, len0_i, len1_i, data0_i, data1_i, valid0_i, valid1_i,
        input  ready_o, gnt_o, busy_o, done_o, sum_o, src_o
    );

    modport slave (
        input  req_i, len0_i, len1_i, data0_i, data1_i, valid0_i, valid1_i,
        output ready_o, gnt_o, busy_o, done_o, sum_o, src_o
    );
endinterface

// File: rtl/xor_burst_arbiter.sv
// Round-robin arbiter sharing one XOR accumulator between two burst
// producers; each granted burst is folded into a checksum reported on done.
module xor_burst_arbiter #(
    parameter int NB_G  = 16,
    parameter int LEN_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    xor_burst_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       gnt_r, gnt_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic [NB_G-1:0]  acc_r, acc_s;
    logic [NB_G-1:0]  sum_r;
    logic             src_r;
    logic             last_r;
    logic             win_s;
    logic             hs_s;
    logic [NB_G-1:0]  word_s;

    // Accumulate stage: carry-free bitwise fold, width preserved.
    function automatic logic [NB_G-1:0] xor_cell(input logic [NB_G-1:0] a,
                                                 input logic [NB_G-1:0] b);
        return a ^ b;
    endfunction

    // Arbitration, word selection and next-state decode.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        win_s   = 1'b0;
        hs_s    = 1'b0;
        word_s  = {NB_G{1'b0}};

        if (bus.req_i == 2'b11) begin
            win_s = ~last_r;
        end else begin
            win_s = bus.req_i[1];
        end

        // Only the granted requester's valid can ever form a handshake.
        if (gnt_r[1]) begin
            word_s = bus.data1_i;
            hs_s   = bus.valid1_i;
        end else begin
            word_s = bus.data0_i;
            hs_s   = bus.valid0_i;
        end

        case (state_r)
            IDLE: begin
                if (bus.req_i != 2'b00) begin
                    gnt_s = win_s ? 2'b10 : 2'b01;
                    cnt_s = win_s ? bus.len1_i : bus.len0_i;
                    acc_s = {NB_G{1'b0}};
                    if (cnt_s == {LEN_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    gnt_s = 2'b00;
                end
            end
            RUN: begin
                if (hs_s) begin
                    acc_s = xor_cell(acc_r, word_s);
                    cnt_s = cnt_r - LEN_W'(1);
                    if (cnt_r == LEN_W'(1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
                gnt_s   = 2'b00;
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 2'b00;
            end
        endcase
    end

    // State, accumulator and result registers; result captured on entry to DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            cnt_r   <= {LEN_W{1'b0}};
            acc_r   <= {NB_G{1'b0}};
            sum_r   <= {NB_G{1'b0}};
            src_r   <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            if (state_s == DONE) begin
                sum_r  <= acc_s;
                src_r  <= gnt_s[1];
                last_r <= gnt_s[1];
            end
        end
    end

    assign bus.gnt_o   = gnt_r;
    assign bus.ready_o = (state_r == RUN) ? gnt_r : 2'b00;
    assign bus.busy_o  = (state_r != IDLE);
    assign bus.done_o  = (state_r == DONE);
    assign bus.sum_o   = sum_r;
    assign bus.src_o   = src_r;
endmodule
